// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program counter owner; next-fetch selection, kernel tracking,
//            interrupt latching and trap entry (EPC capture, flush, ack).
// Options  : PC_ALIGN_CHECK_EN - misaligned JR target raises an ILLOP trap
//            instead of silently clearing JRaddr[1:0].
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] JRaddr,
  input  logic        IRQ,
  output logic [31:0] PC,
  output logic [31:0] PCplus4,
  output logic        flush,
  output logic [31:0] EPC,
  output logic        IRQ_ack,
  output logic        kernel
);

  localparam logic [2:0] c_SRC_BRANCH = 3'd1;
  localparam logic [2:0] c_SRC_J      = 3'd2;
  localparam logic [2:0] c_SRC_JR     = 3'd3;
  localparam logic [2:0] c_SRC_ILLOP  = 3'd4;

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_irq_ack;
  logic        r_pending;
  logic        r_irq_q;

  logic [31:0] w_pcplus4;
  logic [31:0] w_jr_target;
  logic [31:0] w_next_pc;
  logic        w_illop;
  logic        w_trap;
  logic        w_take_irq;
  logic        w_flush;

  assign w_pcplus4 = r_pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  assign w_illop     = (PCSrc == c_SRC_ILLOP) ||
                       ((PCSrc == c_SRC_JR) && (JRaddr[1:0] != 2'b00));
  assign w_jr_target = {r_pc[31] & JRaddr[31], JRaddr[30:0]};
`else
  assign w_illop     = (PCSrc == c_SRC_ILLOP);
  assign w_jr_target = {r_pc[31] & JRaddr[31], JRaddr[30:0]} & ~32'd3;
`endif

  // Priority chain: stall, illegal op, interrupt (user mode only), then redirects.
  always_comb begin
    w_next_pc  = w_pcplus4;
    w_flush    = 1'b0;
    w_trap     = 1'b0;
    w_take_irq = 1'b0;
    if (stall) begin
      w_next_pc = r_pc;
    end else if (w_illop) begin
      w_next_pc = ILLOP_VEC;
      w_flush   = 1'b1;
      w_trap    = 1'b1;
    end else if (r_pending && !r_pc[31]) begin
      w_next_pc  = XADR_VEC;
      w_flush    = 1'b1;
      w_trap     = 1'b1;
      w_take_irq = 1'b1;
    end else begin
      case (PCSrc)
        c_SRC_BRANCH: begin
          if (BranchTaken) begin
            w_next_pc = {r_pc[31] & ConBA[31], ConBA[30:0]};
            w_flush   = 1'b1;
          end
        end
        c_SRC_J: begin
          w_next_pc = {r_pc[31], w_pcplus4[30:28], JT, 2'b00};
          w_flush   = 1'b1;
        end
        c_SRC_JR: begin
          w_next_pc = w_jr_target;
          w_flush   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_epc     <= 32'd0;
      r_irq_ack <= 1'b0;
      r_pending <= 1'b0;
      r_irq_q   <= 1'b0;
    end else begin
      r_irq_q   <= IRQ;
      // A fresh rising edge wins over the clear of the one being serviced.
      r_pending <= (r_pending & ~w_take_irq) | (IRQ & ~r_irq_q);
      r_irq_ack <= w_take_irq;
      r_pc      <= w_next_pc;
      if (w_trap) begin
        r_epc <= r_pc;
      end
    end
  end

  assign PC      = r_pc;
  assign PCplus4 = w_pcplus4;
  assign flush   = w_flush;
  assign EPC     = r_epc;
  assign IRQ_ack = r_irq_ack;
  assign kernel  = r_pc[31];

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed and randomized self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] c_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] c_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] c_XADR_VEC  = 32'h8000_0008;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit c_ALIGN = 1'b1;
`else
  localparam bit c_ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic        BranchTaken = 1'b0;
  logic [31:0] ConBA = 32'd0;
  logic [25:0] JT = 26'd0;
  logic [31:0] JRaddr = 32'd0;
  logic        IRQ = 1'b0;
  logic [31:0] PC, PCplus4, EPC;
  logic        flush, IRQ_ack, kernel;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] m_pc, m_epc;
  logic        m_ack, m_pend, m_irqq;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc),
    .BranchTaken(BranchTaken), .ConBA(ConBA), .JT(JT), .JRaddr(JRaddr),
    .IRQ(IRQ), .PC(PC), .PCplus4(PCplus4), .flush(flush), .EPC(EPC),
    .IRQ_ack(IRQ_ack), .kernel(kernel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next PC / EPC / flush derived straight from the redirect rules.
  task automatic model_next(output logic [31:0] npc, output logic [31:0] nepc,
                            output logic fl, output logic tk_irq);
    logic [31:0] p4;
    logic [31:0] kmask;
    bit          illop;
    p4     = m_pc + 32'd4;
    kmask  = m_pc[31] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    illop  = (PCSrc == 3'd4) || (c_ALIGN && PCSrc == 3'd3 && JRaddr[1:0] != 2'b00);
    npc    = p4;
    nepc   = m_epc;
    fl     = 1'b0;
    tk_irq = 1'b0;
    if (stall) begin
      npc = m_pc;
    end else if (illop) begin
      npc = c_ILLOP_VEC; nepc = m_pc; fl = 1'b1;
    end else if (m_pend && !m_pc[31]) begin
      npc = c_XADR_VEC; nepc = m_pc; fl = 1'b1; tk_irq = 1'b1;
    end else if (PCSrc == 3'd1 && BranchTaken) begin
      npc = ConBA & kmask; fl = 1'b1;
    end else if (PCSrc == 3'd2) begin
      npc = (m_pc & 32'h8000_0000) | (p4 & 32'h7000_0000) | ({6'd0, JT} * 4); fl = 1'b1;
    end else if (PCSrc == 3'd3) begin
      npc = JRaddr & kmask & 32'hFFFF_FFFC; fl = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] npc, nepc;
    logic        fl, tk;
    if (reset) begin
      m_pc = c_RESET_PC; m_epc = 32'd0; m_ack = 1'b0; m_pend = 1'b0; m_irqq = 1'b0;
    end else begin
      model_next(npc, nepc, fl, tk);
      m_ack  = tk;
      m_pend = (m_pend && !tk) || (IRQ && !m_irqq);
      m_irqq = IRQ;
      m_pc   = npc;
      m_epc  = nepc;
    end
  end

  always @(negedge clk) begin
    logic [31:0] npc, nepc;
    logic        fl, tk;
    if (chk_en) begin
      model_next(npc, nepc, fl, tk);
      check("m_PC", PC, m_pc);
      check("m_PCplus4", PCplus4, m_pc + 32'd4);
      check("m_kernel", {31'd0, kernel}, {31'd0, m_pc[31]});
      check("m_EPC", EPC, m_epc);
      check("m_IRQ_ack", {31'd0, IRQ_ack}, {31'd0, m_ack});
      check("m_flush", {31'd0, flush}, {31'd0, fl});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jr(input logic [31:0] a);
    PCSrc = 3'd3; JRaddr = a;
    tick();
  endtask

  initial begin
    tick();
    check("rst_PC", PC, 32'h8000_0000);
    check("rst_EPC", EPC, 32'd0);
    check("rst_ack", {31'd0, IRQ_ack}, 32'd0);
    check("rst_kernel", {31'd0, kernel}, 32'd1);
    chk_en = 1'b1;
    reset  = 1'b0;
    #1 check("seq_flush", {31'd0, flush}, 32'd0);
    tick(); check("seq_PC1", PC, 32'h8000_0004);
    tick(); check("seq_PC2", PC, 32'h8000_0008);
    tick(); check("seq_PC3", PC, 32'h8000_000C);
    tick(); check("seq_PC4", PC, 32'h8000_0010);

    PCSrc = 3'd3; JRaddr = 32'h0040_0000;
    #1 check("jr_flush", {31'd0, flush}, 32'd1);
    tick(); check("jr_user", PC, 32'h0040_0000);
    check("jr_kernel", {31'd0, kernel}, 32'd0);
    jr(32'h8000_1000); check("jr_nokern", PC, 32'h0000_1000);

    jr(32'h0040_0000);
    PCSrc = 3'd1; BranchTaken = 1'b1; ConBA = 32'h0040_0040;
    #1 check("br_flush", {31'd0, flush}, 32'd1);
    tick(); check("br_taken", PC, 32'h0040_0040);
    jr(32'h0040_0000);
    PCSrc = 3'd1; BranchTaken = 1'b0;
    #1 check("br_nt_flush", {31'd0, flush}, 32'd0);
    tick(); check("br_not", PC, 32'h0040_0004);

    jr(32'h0040_0100);
    PCSrc = 3'd0; stall = 1'b1; IRQ = 1'b1;
    tick(); check("stall_PC1", PC, 32'h0040_0100);
    check("stall_ack1", {31'd0, IRQ_ack}, 32'd0);
    tick(); check("stall_PC2", PC, 32'h0040_0100);
    stall = 1'b0;
    #1 check("irq_flush", {31'd0, flush}, 32'd1);
    tick(); check("irq_PC", PC, 32'h8000_0008);
    check("irq_EPC", EPC, 32'h0040_0100);
    check("irq_ack", {31'd0, IRQ_ack}, 32'd1);
    tick(); check("ack_pulse", {31'd0, IRQ_ack}, 32'd0);
    jr(32'h0040_0300);
    PCSrc = 3'd0;
    #1 check("no_retrap", {31'd0, flush}, 32'd0);
    tick(); check("no_retrap_PC", PC, 32'h0040_0304);

    IRQ = 1'b0; jr(32'h0040_0200);
    PCSrc = 3'd4; IRQ = 1'b1;
    tick(); check("ill_PC", PC, 32'h8000_0004);
    check("ill_EPC", EPC, 32'h0040_0200);
    check("ill_ack", {31'd0, IRQ_ack}, 32'd0);
    jr(32'h0040_0200); check("ill_ret", PC, 32'h0040_0200);
    PCSrc = 3'd0;
    tick(); check("pend_PC", PC, 32'h8000_0008);
    check("pend_ack", {31'd0, IRQ_ack}, 32'd1);

    jr(32'h0040_0000);
    jr(32'h0040_0002);
`ifdef PC_ALIGN_CHECK_EN
    check("align_PC", PC, 32'h8000_0004);
    check("align_EPC", EPC, 32'h0040_0000);
`else
    check("align_PC", PC, 32'h0040_0000);
`endif

    reset = 1'b1; tick();
    check("mid_rst_PC", PC, 32'h8000_0000);
    check("mid_rst_EPC", EPC, 32'd0);
    reset = 1'b0;
    jr(32'hFFFF_FFFC);
    check("wrap_p4", PCplus4, 32'd0);
    PCSrc = 3'd0; tick();
    check("wrap_PC", PC, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(99) == 0);
      stall       = ($urandom_range(3) == 0);
      PCSrc       = 3'($urandom_range(7));
      BranchTaken = 1'($urandom);
      ConBA       = $urandom;
      JT          = 26'($urandom);
      JRaddr      = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(7) == 0) IRQ = ~IRQ;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
